// File: rtl/mux_arb_n.sv
// N-channel registered stream multiplexer with round-robin, fixed-priority or
// forced-select arbitration feeding a single valid/ready output register.

module mux_arb_n_chk #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 2
) (
  input logic                clk,
  input logic                rst_n,
  input logic [CHANNELS-1:0] in_valid,
  input logic [CHANNELS-1:0] in_ready,
  input logic                force_en,
  input logic [SEL_W-1:0]    force_sel,
  input logic                out_valid,
  input logic [WIDTH-1:0]    out_data,
  input logic [SEL_W-1:0]    out_sel,
  input logic                out_ready
);

  logic [CHANNELS-1:0] w_force_oh;
  assign w_force_oh = CHANNELS'(1) << force_sel;

  a_param_range: assert property (@(posedge clk) (CHANNELS >= 2) && (CHANNELS <= 16));

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready & ~in_valid) == '0);

  a_bp_blocks_input: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |-> (in_ready == '0));

  // A stalled beat must not change until the consumer takes it.
  a_bp_holds_beat: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

  a_force_only_sel: assert property (@(posedge clk) disable iff (!rst_n)
    force_en |-> ((in_ready & ~w_force_oh) == '0));

endmodule

module mux_arb_n #(
  parameter int   WIDTH    = 8,
  parameter int   CHANNELS = 4,
  parameter int   MODE     = 0,
  localparam int  SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    r_ptr;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_sel;

  logic [CHANNELS-1:0] w_elig;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_gidx;
  logic                w_found;
  logic                w_hit;
  logic [SEL_W-1:0]    w_start;
  logic [SEL_W:0]      w_sum;
  logic [SEL_W-1:0]    w_idx;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0]    w_data;
  logic                w_can_load;
  logic                w_load;

  // Eligibility: an out-of-range force_sel matches no channel.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_elig[i] = in_valid[i] & (~force_en | (force_sel == SEL_W'(i)));
    end
  end

  // Scan from the start index with wrap; first eligible channel wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    w_start = (MODE == 1) ? '0 : r_ptr;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum          = {1'b0, w_start} + (SEL_W+1)'(k);
      w_idx          = (w_sum >= (SEL_W+1)'(CHANNELS)) ? SEL_W'(w_sum - (SEL_W+1)'(CHANNELS))
                                                       : SEL_W'(w_sum);
      w_hit          = w_elig[w_idx] & ~w_found;
      w_grant[w_idx] = w_hit;
      w_gidx         = w_hit ? w_idx : w_gidx;
      w_found        = w_found | w_hit;
    end
  end

  // One-hot AND-OR select of the granted channel's data.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_data = w_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  assign w_can_load = ~r_out_valid | out_ready;
  assign w_load     = w_found & w_can_load;
  assign w_ptr_nxt  = (w_gidx == SEL_W'(CHANNELS-1)) ? '0 : (w_gidx + SEL_W'(1));
  assign in_ready   = w_grant & {CHANNELS{w_can_load}};

  // Round-robin pointer, advanced past the winner on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_load && (MODE == 0)) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output register: load, drain, or hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

  mux_arb_n_chk #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .SEL_W    (SEL_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (r_out_valid),
    .out_data  (r_out_data),
    .out_sel   (r_out_sel),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: round-robin, fixed-priority and 2:1 instances.

module tb_mux_arb_n;

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        fen;
    logic [1:0]  fsel;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  vld;
  logic [31:0] dat;
  logic        fen;
  logic [1:0]  fsel;
  logic        ordy;
  logic [3:0]  rdy0, rdy1;
  logic        ov0, ov1;
  logic [7:0]  od0, od1;
  logic [1:0]  os0, os1;
  logic [1:0]  vld2, dat2, rdy2;
  logic        fen2, fsel2, ordy2, ov2, od2, os2;

  int n_chk = 0;
  int n_err = 0;
  vec_t tbl [18];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(dat), .in_ready(rdy0),
    .force_en(fen), .force_sel(fsel), .out_valid(ov0), .out_data(od0),
    .out_sel(os0), .out_ready(ordy));

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(dat), .in_ready(rdy1),
    .force_en(fen), .force_sel(fsel), .out_valid(ov1), .out_data(od1),
    .out_sel(os1), .out_ready(ordy));

  mux_arb_n #(.WIDTH(1), .CHANNELS(2), .MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld2), .in_data(dat2), .in_ready(rdy2),
    .force_en(fen2), .force_sel(fsel2), .out_valid(ov2), .out_data(od2),
    .out_sel(os2), .out_ready(ordy2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic fe,
                              input logic [1:0] fs, input logic r, input logic [3:0] er,
                              input logic eov, input logic [7:0] eod, input logic [1:0] eos);
    vec_t t;
    t.vld = v; t.dat = d; t.fen = fe; t.fsel = fs; t.ordy = r;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_os = eos;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    logic a, b, s;
    logic [31:0] da, db, dd;
    da = 32'hA3A2A1A0;
    db = 32'h5C121110;
    dd = 32'hD3D2D1D0;
    // fairness, forced select, forced idle drain, backpressure, wrap scan
    tbl[0]  = mk(4'b1111, da, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    tbl[1]  = mk(4'b1111, da, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    tbl[2]  = mk(4'b1111, da, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    tbl[3]  = mk(4'b1111, da, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    tbl[4]  = mk(4'b1111, da, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    tbl[5]  = mk(4'b1111, da, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    tbl[6]  = mk(4'b1111, da, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    tbl[7]  = mk(4'b1011, da, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2);
    tbl[8]  = mk(4'b1011, da, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2);
    tbl[9]  = mk(4'b1000, db, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h5C, 2'd3);
    tbl[10] = mk(4'b0111, db, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd3);
    tbl[11] = mk(4'b0111, db, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd3);
    tbl[12] = mk(4'b0111, db, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd3);
    tbl[13] = mk(4'b0111, db, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd3);
    tbl[14] = mk(4'b0111, db, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    tbl[15] = mk(4'b0000, db, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0);
    tbl[16] = mk(4'b1001, db, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h5C, 2'd3);
    tbl[17] = mk(4'b1001, db, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);

    rst_n = 1'b0; vld = '0; dat = '0; fen = 1'b0; fsel = '0; ordy = 1'b1;
    vld2 = '0; dat2 = '0; fen2 = 1'b0; fsel2 = 1'b0; ordy2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ov0", 32'(ov0), 32'd0);  chk("rst od0", 32'(od0), 32'd0);  chk("rst os0", 32'(os0), 32'd0);
    chk("rst ov1", 32'(ov1), 32'd0);  chk("rst od1", 32'(od1), 32'd0);  chk("rst os1", 32'(os1), 32'd0);
    chk("rst ov2", 32'(ov2), 32'd0);  chk("rst od2", 32'(od2), 32'd0);  chk("rst os2", 32'(os2), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      vld = tbl[i].vld; dat = tbl[i].dat; fen = tbl[i].fen; fsel = tbl[i].fsel; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(rdy0), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(ov0), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_data", i), 32'(od0), 32'(tbl[i].e_od));
      chk($sformatf("v%0d out_sel", i), 32'(os0), 32'(tbl[i].e_os));
    end

    // fixed priority on the MODE=1 instance
    @(negedge clk);
    rst_n = 1'b0; vld = '0; fen = 1'b0; ordy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; vld = 4'b1010; dat = dd;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("prio%0d in_ready", c), 32'(rdy1), 32'h2);
      @(posedge clk); #1;
      chk($sformatf("prio%0d out_sel", c), 32'(os1), 32'd1);
      chk($sformatf("prio%0d out_data", c), 32'(od1), 32'hD1);
      @(negedge clk);
    end
    vld = 4'b1000;
    #1;
    chk("prio drop in_ready", 32'(rdy1), 32'h8);
    @(posedge clk); #1;
    chk("prio drop out_sel", 32'(os1), 32'd3);
    chk("prio drop out_data", 32'(od1), 32'hD3);

    // reset mid-stream with a stalled beat
    @(negedge clk);
    vld = '0; ordy = 1'b1;
    @(negedge clk);
    vld = 4'b0100; ordy = 1'b0;
    @(posedge clk); #1;
    chk("stall load ov", 32'(ov0), 32'd1);
    chk("stall load od", 32'(od0), 32'hD2);
    @(negedge clk);
    vld = '0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async rst ov", 32'(ov0), 32'd0);
    chk("async rst od", 32'(od0), 32'd0);
    chk("async rst os", 32'(os0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    chk("no replay ov", 32'(ov0), 32'd0);
    @(negedge clk);
    vld = 4'b1111;
    #1;
    chk("post rst in_ready", 32'(rdy0), 32'h1);
    @(posedge clk); #1;
    chk("post rst out_sel", 32'(os0), 32'd0);
    chk("post rst out_data", 32'(od0), 32'hD0);

    // exhaustive 2:1 mux truth table through the forced select
    vld2 = 2'b11; fen2 = 1'b1; ordy2 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      a = n[0]; b = n[1]; s = n[2];
      dat2 = {b, a}; fsel2 = s;
      #1;
      chk($sformatf("mux2 s%0d b%0d a%0d in_ready", s, b, a), 32'(rdy2), s ? 32'h2 : 32'h1);
      @(posedge clk); #1;
      chk($sformatf("mux2 s%0d b%0d a%0d out_data", s, b, a), 32'(od2), 32'(s ? b : a));
      chk($sformatf("mux2 s%0d b%0d a%0d out_sel", s, b, a), 32'(os2), 32'(s));
      chk($sformatf("mux2 s%0d b%0d a%0d out_valid", s, b, a), 32'(ov2), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
Parametrised N-channel, W-bit registered multiplexer that generalises the two-input gate-level mux into a channel selector. It takes valid/ready streams on CHANNELS inputs and picks one per cycle, using round-robin or fixed-priority arbitration, or a forced select that mirrors the classic S input. The chosen beat goes into a single output register and leaves on a valid/ready stream. It sits between multiple producers (register-file read ports, fetch/load units) and a shared consumer in the CPU datapath.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with lowest index winning.
- SEL_W, $clog2(CHANNELS), select/index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  CHANNELS  per-channel beat valid.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept; combinational.
- force_en  input  1  when 1, only channel force_sel is eligible.
- force_sel  input  SEL_W  forced channel index.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - A beat held at reset is discarded and never replayed.
- Eligibility:
  - elig[i] = in_valid[i].
  - If force_en=1: elig = one-hot(force_sel) & in_valid.
  - force_sel >= CHANNELS gives elig=0.
- Grant (combinational, one-hot or zero):
  - MODE=0: first eligible index scanning ptr, ptr+1, … wrapping modulo CHANNELS.
  - MODE=1: lowest eligible index.
- Accept signal:
  - can_load = !out_valid || out_ready.
  - in_ready[i] = grant[i] && can_load.
  - All other in_ready bits are 0. Exactly zero or one channel transfers per cycle.
- Transfer (on rising edge when grant g exists and can_load=1):
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - Latency is 1 cycle from input handshake to out_valid.
- Pointer update:
  - On a transfer in MODE=0, ptr <= (g+1) mod CHANNELS.
  - The pointer also updates under force_en.
  - MODE=1 never changes ptr.
- Drain: out_valid && out_ready with no new grant gives out_valid <= 0. out_data and out_sel keep their last value.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are held stable and all in_ready=0.
- Simultaneous drain and load: out_valid stays 1 and the new beat replaces the old one in the same edge. Full throughput is one beat per cycle.
- Inputs must not depend combinationally on in_ready's value beyond the handshake rule. No combinational path runs from out_ready to out_data.
- Pointer wrap: when g = CHANNELS-1, the next ptr is 0.

Test Plan:
- Reset mid-stream:
  - Stimulus: hold out_ready=0 with a beat loaded, then assert rst_n=0 asynchronously between edges.
  - Required: out_valid=0, out_data=0, out_sel=0 immediately. After release, the first grant starts at channel 0.
- Round-robin fairness (CHANNELS=4, WIDTH=8, MODE=0):
  - Stimulus: all in_valid=1, data i = 8'hA0+i, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3,A0; one beat per cycle.
- Fixed priority (MODE=1):
  - Stimulus: in_valid=4'b1010 for 3 cycles.
  - Required: out_sel=1 every cycle and in_ready=4'b0010. Then drop in_valid[1]; required: out_sel=3.
- Forced select:
  - Stimulus: force_en=1, force_sel=2, in_valid=4'b1111.
  - Required: only in_ready[2]=1, out_sel=2.
  - Stimulus: force_sel=2 with in_valid[2]=0. Required: no transfer; out_valid drops after the drain.
- Backpressure:
  - Stimulus: load 8'h5C from channel 3, then out_ready=0 for 4 cycles with other channels valid.
  - Required: out_data=5C and out_sel=3 stay stable and in_ready=0. When out_ready=1, the next grant is channel 0 (ptr wrapped from 3).
- Exhaustive CHANNELS=2, WIDTH=1 with force_en=1:
  - Stimulus: sweep all 8 combinations of A (ch0), B (ch1), S (force_sel), with both valids high and out_ready=1.
  - Required: one cycle later, out_data = S ? B : A, matching the two-input mux truth table.
